// File: rtl/div_if.sv
// ============================================================================
// div_if : request/response channel between the core and the divide unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      div_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport slave (
    input  in_valid, div_op, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_result, busy
  );

  modport master (
    output in_valid, div_op, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_result, busy
  );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : iterative radix-2 restoring RV32M DIV/DIVU/REM/REMU unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  div_if.slave      bus
);

  localparam logic [1:0]      c_IDLE = 2'd0;
  localparam logic [1:0]      c_CALC = 2'd1;
  localparam logic [1:0]      c_DONE = 2'd2;
  localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ONES = {XLEN{1'b1}};

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic            r_signed;
  logic            r_is_rem;
  logic            r_sign_a;
  logic            r_sign_b;

  logic            w_accept;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_last;
  logic [XLEN-1:0] w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_final;

  // Request decode; flush blocks acceptance in the same cycle.
  assign w_accept  = bus.in_valid && (r_state == c_IDLE) && !bus.flush;
  assign w_signed  = ~bus.div_op[0];
  assign w_is_rem  = bus.div_op[1];
  assign w_b_zero  = (bus.in_b == '0);
  assign w_ovf     = w_signed && (bus.in_a == c_MIN) && (bus.in_b == c_ONES);
  assign w_special = w_b_zero || w_ovf;
  assign w_a_abs   = (w_signed && bus.in_a[XLEN-1]) ? -bus.in_a : bus.in_a;
  assign w_b_abs   = (w_signed && bus.in_b[XLEN-1]) ? -bus.in_b : bus.in_b;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = w_is_rem ? bus.in_a : c_ONES;
    else          w_special_res = w_is_rem ? '0 : c_MIN;
  end

  // Restoring step; the bit shifted out of r_rem forces a subtract since
  // the true partial remainder then exceeds any XLEN-bit divisor.
  assign w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_ge     = r_rem[XLEN-1] || (w_rem_sh >= r_div);
  assign w_rem_nx = w_ge ? (w_rem_sh - r_div) : w_rem_sh;
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  always_comb begin
    w_final = '0;
    if (r_is_rem) w_final = (r_signed && r_sign_a) ? -w_rem_nx : w_rem_nx;
    else          w_final = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quo_nx : w_quo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_accept) w_next = w_special ? c_DONE : c_CALC;
        c_CALC:  if (w_last) w_next = c_DONE;
        c_DONE:  if (bus.out_ready) w_next = c_IDLE;
        default: w_next = c_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready   = (r_state == c_IDLE) && !bus.flush;
    bus.out_valid  = (r_state == c_DONE);
    bus.busy       = (r_state != c_IDLE);
    bus.out_result = r_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_signed <= 1'b0;
      r_is_rem <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (!bus.flush) begin
      if (r_state == c_IDLE && w_accept) begin
        r_signed <= w_signed;
        r_is_rem <= w_is_rem;
        r_sign_a <= w_signed && bus.in_a[XLEN-1];
        r_sign_b <= w_signed && bus.in_b[XLEN-1];
        r_cnt    <= '0;
        r_rem    <= '0;
        r_quo    <= w_a_abs;
        r_div    <= w_b_abs;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == c_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        if (w_last) r_result <= w_final;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed vectors with a queue scoreboard for div_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  localparam logic [1:0] c_DIV  = 2'b00;
  localparam logic [1:0] c_DIVU = 2'b01;
  localparam logic [1:0] c_REM  = 2'b10;
  localparam logic [1:0] c_REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  div_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected value.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", bus.out_result, 32'hxxxx_xxxx);
      end else begin
        chk("result", bus.out_result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    int w;
    bus.in_valid = 1'b1;
    bus.div_op   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    #1;
    bus.in_valid = 1'b0;
    bus.div_op   = 2'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic wait_result(input string nm, input int exp_lat);
    int edges;
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk(nm, 32'(edges), 32'(exp_lat));
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(op, a, b, exp, 1'b1);
    wait_result(nm, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.div_op    = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result,     32'd0);
    chk("rst_busy",       32'(bus.busy),      32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),  32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("lat_divu_100_7", c_DIVU, 32'd100, 32'd7, 32'd14, 32);
    run_op("lat_remu_100_7", c_REMU, 32'd100, 32'd7, 32'd2, 32);
    run_op("lat_div_m7_2",   c_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run_op("lat_rem_m7_2",   c_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run_op("lat_rem_7_m2",   c_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 32);
    run_op("lat_div_min_2",  c_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 32);
    run_op("lat_divu_big",   c_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32);
    run_op("lat_remu_big",   c_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32);
    run_op("lat_divu_min_m1", c_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);
    run_op("lat_divu_5_0",   c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("lat_rem_5_0",    c_REM,  32'd5, 32'd0, 32'd5, 0);
    run_op("lat_div_ovf",    c_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("lat_rem_ovf",    c_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Backpressure: result held in DONE, then back-to-back request.
    bus.out_ready = 1'b0;
    issue(c_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1);
    wait_result("lat_div_100_m7", 32);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid",  32'(bus.out_valid), 32'd1);
      chk("bp_out_result", bus.out_result,     32'hFFFF_FFF2);
      chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
    run_op("lat_b2b_divu", c_DIVU, 32'd1000, 32'd10, 32'd100, 32);

    // Flush at counter == 10.
    issue(c_DIVU, 32'h1234_5678, 32'd3, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    chk("flush_in_ready_high", 32'(bus.in_ready),  32'd1);
    chk("flush_out_valid",     32'(bus.out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    run_op("lat_divu_9_3", c_DIVU, 32'd9, 32'd3, 32'd3, 32);

    // Asynchronous reset between edges mid-CALC.
    issue(c_DIVU, 32'd1000, 32'd7, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_reset", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("areset_busy",      32'(bus.busy),      32'd0);
    chk("areset_in_ready",  32'(bus.in_ready),  32'd1);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("areset_no_result", 32'(seen), 32'd0);
    run_op("lat_after_reset", c_REMU, 32'd1000, 32'd7, 32'd6, 32);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit: a responder on a valid/ready request channel, with a valid/ready response channel.
- Sits beside the combinational alu in the execute stage. The core issues DIV/DIVU/REM/REMU operands, stalls until the response arrives, and consumes the result.
- Radix-2 restoring division, one quotient bit per clock. Special cases take a single-cycle fast path.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, $clog2(XLEN): width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- div_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- in_a  in  XLEN  dividend.
- in_b  in  XLEN  divisor.
- flush  in  1  synchronous abort; discards any in-flight or held result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  quotient or remainder, per the latched div_op.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - out_valid=0, out_result=0, busy=0, in_ready=1.
  - Counter, quotient, remainder and sign flags all 0.
  - Asserting reset mid-CALC or in DONE drops the operation immediately; no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge N, latch div_op and the operand signs.
    - Special case: go to DONE and load out_result at edge N. out_valid is high in cycle N+1.
    - Otherwise: go to CALC, load |a| and |b| (magnitudes only for signed ops), counter=0.
  - CALC: in_ready=0.
    - Each edge shifts remainder:quotient left by 1 and subtracts the divisor when the result is non-negative (restoring step).
    - The counter increments each edge.
    - At the edge where counter==XLEN-1 (the 32nd CALC edge, N+32), go to DONE and load the sign-corrected out_result in the same edge.
    - Normal latency: out_valid is first high in cycle N+33, i.e. 32 edges after the accept edge.
  - DONE: out_valid=1 and out_result is held stable until out_valid&&out_ready. On that edge go to IDLE, out_valid=0; out_result keeps its value.
    - in_ready stays 0 throughout DONE. A new request cannot be accepted in the same cycle as the response handshake.
- Sign rules:
  - Signed quotient is negated when sign(a)!=sign(b).
  - Signed remainder takes the sign of the dividend.
  - Unsigned ops never negate.
- Special cases (fast path, RISC-V semantics):
  - in_b==0: DIV/DIVU result = all ones (32'hFFFF_FFFF); REM/REMU result = in_a.
  - DIV/REM with in_a==32'h8000_0000 and in_b==32'hFFFF_FFFF: DIV = 32'h8000_0000, REM = 0.
- Flush:
  - flush high at an edge forces IDLE and out_valid=0, in any state.
  - flush takes priority over the accept and response handshakes in the same cycle.
  - in_ready is 0 in the cycle flush is high, so no request is accepted.
- Invalid input: in_a, in_b and div_op are sampled only on the accept edge. Changes afterwards have no effect.

Test Plan:
- DIVU 100/7 -> after accept, out_valid rises exactly 32 edges later; result 14. REMU with the same operands -> 2.
- DIV -7/2 (32'hFFFF_FFF9, 2) -> 32'hFFFF_FFFD (-3). REM with the same operands -> 32'hFFFF_FFFF (-1). REM 7/-2 -> 1.
- Divide by zero, DIVU 5/0 -> 32'hFFFF_FFFF with out_valid one cycle after accept. REM 5/0 -> 5.
- Overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000. REM with the same operands -> 0. Both via the one-cycle fast path.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stay stable and in_ready=0. Raise out_ready -> IDLE on the next edge, then accept a back-to-back request.
- Abort and reset:
  - flush at CALC counter==10 -> out_valid never rises; in_ready=1 the next cycle; a following DIVU 9/3 -> 3.
  - rst_n pulsed low mid-CALC, between edges -> out_valid=0, busy=0 and in_ready=1 immediately, before the next edge.
